dom_rand_gen: RTL and testbench

- Fresh-randomness source for the first-order DOM AND gates of the masked Ascon S-box layer.
- Supplies Z_WIDTH mask bits per cycle; each bit drives the z0 input of one DOM AND.
- Based on a 64-bit Fibonacci LFSR with seed-load handshake, warm-up phase and a bounded-use counter that forces periodic reseeding.
- Sits directly upstream of the S-box DOM gates; seeded from the system TRNG interface.

---
 rtl/dom_pkg.sv | 22 ++
 rtl/lfsr_advance.sv | 22 ++
 rtl/dom_rand_gen.sv | 94 +++++++++
 tb/tb_dom_rand_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dom_pkg.sv
// Shared constants for the DOM fresh-randomness sources: LFSR geometry,
// feedback taps, zero-seed substitute and the generator state encoding.
package dom_pkg;

    localparam int LFSR_W = 64;

    // Taps for x^64 + x^63 + x^61 + x^60 + 1
    localparam int TAP_A = 63;
    localparam int TAP_B = 62;
    localparam int TAP_C = 60;
    localparam int TAP_D = 59;

    localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 64'h1;

    typedef enum logic [1:0] {
        ST_UNSEEDED  = 2'd0,
        ST_WARMUP    = 2'd1,
        ST_RUN       = 2'd2,
        ST_EXHAUSTED = 2'd3
    } dom_state_e;

endpackage

// File: rtl/lfsr_advance.sv
// Combinational unroll of STEPS Fibonacci LFSR shifts; reused by any
// randomness source that needs several fresh bits per cycle.
module lfsr_advance
    import dom_pkg::*;
#(
    parameter int STEPS = 5
) (
    input  logic [LFSR_W-1:0] i_s,
    output logic [LFSR_W-1:0] o_s
);

    logic [LFSR_W-1:0] w_s;

    always_comb begin
        w_s = i_s;
        for (int k = 0; k < STEPS; k++) begin
            w_s = {w_s[LFSR_W-2:0], w_s[TAP_A] ^ w_s[TAP_B] ^ w_s[TAP_C] ^ w_s[TAP_D]};
        end
        o_s = w_s;
    end

endmodule

// File: rtl/dom_rand_gen.sv
// Fresh-mask generator for the masked Ascon S-box DOM AND gates: seeded
// LFSR with warm-up and a bounded number of words per seed.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_UNSEEDED  | no seed since reset; no output, reseed requested
// ST_WARMUP    | advancing once per cycle to decorrelate from the seed
// ST_RUN       | z valid; one advance per accepted word
// ST_EXHAUSTED | word budget spent; holds until the next seed
module dom_rand_gen
    import dom_pkg::*;
#(
    parameter int Z_WIDTH         = 5,
    parameter int WARMUP_CYCLES   = 16,
    parameter int RESEED_INTERVAL = 1024,
    parameter int CNT_W           = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LFSR_W-1:0]  seed,
    input  logic               seed_valid,
    output logic               seed_ready,
    output logic [Z_WIDTH-1:0] z,
    output logic               z_valid,
    input  logic               z_ready,
    output logic               reseed_req
);

    localparam logic [CNT_W-1:0] WARM_LD = CNT_W'(WARMUP_CYCLES);
    localparam logic [CNT_W-1:0] RUN_LD  = CNT_W'(RESEED_INTERVAL);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    dom_state_e        r_state;
    logic [LFSR_W-1:0] r_s;
    logic [CNT_W-1:0]  r_cnt;
    logic [LFSR_W-1:0] w_s_adv;
    logic [LFSR_W-1:0] w_seed_ld;
    logic              w_seed_hs;

    lfsr_advance #(.STEPS(Z_WIDTH)) u_adv (
        .i_s (r_s),
        .o_s (w_s_adv)
    );

    assign seed_ready = 1'b1;
    assign w_seed_hs  = seed_valid & seed_ready;
    assign w_seed_ld  = (seed == '0) ? ZERO_SEED_SUB : seed;

    // Outputs decode registered state only; no input reaches z or z_valid.
    assign z          = r_s[Z_WIDTH-1:0];
    assign z_valid    = (r_state == ST_RUN);
    assign reseed_req = (r_state == ST_UNSEEDED) || (r_state == ST_EXHAUSTED);

    // r_cnt is a down-counter: remaining warm-up advances, then remaining words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_UNSEEDED;
            r_s     <= '0;
            r_cnt   <= '0;
        end else if (w_seed_hs) begin
            // A concurrently accepted z word is simply dropped with the old seed.
            r_s <= w_seed_ld;
            if (WARMUP_CYCLES == 0) begin
                r_state <= ST_RUN;
                r_cnt   <= RUN_LD;
            end else begin
                r_state <= ST_WARMUP;
                r_cnt   <= WARM_LD;
            end
        end else begin
            case (r_state)
                ST_WARMUP: begin
                    r_s   <= w_s_adv;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state <= ST_RUN;
                        r_cnt   <= RUN_LD;
                    end
                end
                ST_RUN: begin
                    if (z_ready) begin
                        r_s   <= w_s_adv;
                        r_cnt <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) begin
                            r_state <= ST_EXHAUSTED;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dom_rand_gen.sv
// Bench for dom_rand_gen: directed scenarios on two parameterisations plus a
// randomized run against a behavioural model of the generator.
module tb_dom_rand_gen;

    localparam int ZW = 5;

    logic clk;
    logic rst;

    // Instance A: no warm-up, default word budget
    logic [63:0]   a_seed;
    logic          a_seed_valid, a_seed_ready, a_z_valid, a_z_ready, a_reseed_req;
    logic [ZW-1:0] a_z;
    // Instance B: two warm-up advances, four words per seed
    logic [63:0]   b_seed;
    logic          b_seed_valid, b_seed_ready, b_z_valid, b_z_ready, b_reseed_req;
    logic [ZW-1:0] b_z;

    int n_checks = 0;
    int n_fail   = 0;

    dom_rand_gen #(.Z_WIDTH(ZW), .WARMUP_CYCLES(0), .RESEED_INTERVAL(1024), .CNT_W(11)) u_a (
        .clk(clk), .rst(rst), .seed(a_seed), .seed_valid(a_seed_valid),
        .seed_ready(a_seed_ready), .z(a_z), .z_valid(a_z_valid),
        .z_ready(a_z_ready), .reseed_req(a_reseed_req)
    );

    dom_rand_gen #(.Z_WIDTH(ZW), .WARMUP_CYCLES(2), .RESEED_INTERVAL(4), .CNT_W(11)) u_b (
        .clk(clk), .rst(rst), .seed(b_seed), .seed_valid(b_seed_valid),
        .seed_ready(b_seed_ready), .z(b_z), .z_valid(b_z_valid),
        .z_ready(b_z_ready), .reseed_req(b_reseed_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: Z_WIDTH LFSR steps written straight from the polynomial.
    function automatic logic [63:0] ref_adv(input logic [63:0] s);
        logic [63:0] t;
        logic        fb;
        t = s;
        for (int k = 0; k < ZW; k++) begin
            fb = t[63] ^ t[62] ^ t[60] ^ t[59];
            t  = {t[62:0], fb};
        end
        return t;
    endfunction

    task automatic b_load(input logic [63:0] v);
        b_seed       = v;
        b_seed_valid = 1'b1;
        @(negedge clk);
        b_seed_valid = 1'b0;
    endtask

    // Called one cycle after a seed handshake; returns the cycle at which z_valid rose.
    task automatic b_wait_valid(output int lat);
        lat = 1;
        while (!b_z_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Holds z_ready high, checks each delivered word and counts them.
    task automatic b_drain(input string tag, inout logic [63:0] exp_s, output int words);
        words     = 0;
        b_z_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (b_z_valid) begin
                check(tag, b_z, exp_s[ZW-1:0]);
                words++;
                exp_s = ref_adv(exp_s);
            end
            @(negedge clk);
        end
        b_z_ready = 1'b0;
    endtask

    logic [63:0] exp_s, y;
    logic [ZW-1:0] z_seed1 [4];
    int lat, words;

    // Model for the randomized phase
    int          m_mode;   // 0 unseeded, 1 warm-up, 2 run, 3 exhausted
    int          m_warm_done, m_used;
    logic [63:0] m_s;
    logic        sv, zr;
    logic [63:0] sd;

    initial begin
        rst = 1'b0;
        a_seed = '0; a_seed_valid = 1'b0; a_z_ready = 1'b0;
        b_seed = '0; b_seed_valid = 1'b0; b_z_ready = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_zv", a_z_valid, 0);
        check("rst_req", a_reseed_req, 1);
        check("rst_z", a_z, 0);
        check("rst_sr", a_seed_ready, 1);
        rst = 1'b1;
        a_z_ready = 1'b1;
        @(negedge clk);
        a_z_ready = 1'b0;
        check("unseeded_zv", a_z_valid, 0);
        check("unseeded_req", a_reseed_req, 1);
        check("unseeded_z", a_z, 0);

        // Seed 0x15, no warm-up
        a_seed = 64'h15; a_seed_valid = 1'b1;
        @(negedge clk);
        a_seed_valid = 1'b0;
        check("w0_zv", a_z_valid, 1);
        check("w0_req", a_reseed_req, 0);
        check("w0_z", a_z, 5'h15);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_z", a_z, 5'h15);
            check("stall_zv", a_z_valid, 1);
        end
        a_z_ready = 1'b1;
        @(negedge clk);
        a_z_ready = 1'b0;
        check("acc1_z", a_z, ref_adv(64'h15) & 64'h1F);
        check("acc1_z_lit", a_z, 5'h00);

        // Feedback tap: MSB-only seed
        a_seed = 64'h8000_0000_0000_0000; a_seed_valid = 1'b1;
        @(negedge clk);
        a_seed_valid = 1'b0;
        a_z_ready = 1'b1;
        @(negedge clk);
        a_z_ready = 1'b0;
        check("tap_z", a_z, 5'h10);
        a_z_ready = 1'b1;
        @(negedge clk);
        a_z_ready = 1'b0;
        check("tap_z2", a_z, 5'h00);

        // Seed 1 on B: warm-up latency, then exhaust the 4-word budget
        b_load(64'h1);
        check("b_warm_zv", b_z_valid, 0);
        b_wait_valid(lat);
        check("b_warm_lat", lat, 3);
        exp_s = ref_adv(ref_adv(64'h1));
        for (int i = 0; i < 4; i++) begin
            z_seed1[i] = exp_s[ZW-1:0];
            exp_s = ref_adv(exp_s);
        end
        exp_s = ref_adv(ref_adv(64'h1));
        b_drain("b_seed1_z", exp_s, words);
        check("b_budget_words", words, 4);
        check("b_exh_zv", b_z_valid, 0);
        check("b_exh_req", b_reseed_req, 1);

        // Zero seed must behave exactly like seed 1
        b_load(64'h0);
        b_wait_valid(lat);
        check("b_zero_lat", lat, 3);
        b_z_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("b_zero_seq", b_z, z_seed1[i]);
            @(negedge clk);
        end
        b_z_ready = 1'b0;
        check("b_zero_exh", b_reseed_req, 1);

        // Reseed, take two words, then seed and z handshake together
        y = {$urandom, $urandom} | 64'h1;
        b_load(y);
        b_wait_valid(lat);
        check("b_reseed_lat", lat, 3);
        exp_s = ref_adv(ref_adv(y));
        b_z_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("b_pre_z", b_z, exp_s[ZW-1:0]);
            exp_s = ref_adv(exp_s);
            @(negedge clk);
        end
        y = {$urandom, $urandom} | 64'h2;
        b_seed = y; b_seed_valid = 1'b1;
        @(negedge clk);
        b_seed_valid = 1'b0; b_z_ready = 1'b0;
        check("both_zv", b_z_valid, 0);
        check("both_z_seed", b_z, y[ZW-1:0]);
        b_wait_valid(lat);
        check("both_lat", lat, 3);
        exp_s = ref_adv(ref_adv(y));
        b_drain("both_z", exp_s, words);
        check("both_words", words, 4);

        // Async reset in the middle of warm-up
        y = {$urandom, $urandom} | 64'h1F;
        b_load(y);
        check("mid_warm_zv", b_z_valid, 0);
        #2 rst = 1'b0;
        #1;
        check("arst_zv", b_z_valid, 0);
        check("arst_req", b_reseed_req, 1);
        check("arst_z", b_z, 0);
        check("arst_sr", b_seed_ready, 1);
        @(negedge clk);
        rst = 1'b1;

        // Randomized run against the behavioural model
        m_mode = 0; m_s = '0; m_warm_done = 0; m_used = 0;
        for (int c = 0; c < 600; c++) begin
            check("rnd_zv", b_z_valid, (m_mode == 2));
            check("rnd_req", b_reseed_req, (m_mode == 0 || m_mode == 3));
            check("rnd_z", b_z, m_s[ZW-1:0]);
            sv = ($urandom_range(0, 19) == 0);
            sd = ($urandom_range(0, 5) == 0) ? 64'h0 : {$urandom, $urandom};
            zr = ($urandom_range(0, 2) != 0);
            b_seed = sd; b_seed_valid = sv; b_z_ready = zr;
            if (sv) begin
                m_s = (sd == 0) ? 64'h1 : sd;
                m_used = 0; m_warm_done = 0;
                m_mode = 1;
            end else if (m_mode == 1) begin
                m_s = ref_adv(m_s);
                m_warm_done++;
                if (m_warm_done == 2) m_mode = 2;
            end else if (m_mode == 2 && zr) begin
                m_s = ref_adv(m_s);
                m_used++;
                if (m_used == 4) m_mode = 3;
            end
            @(negedge clk);
        end
        b_seed_valid = 1'b0; b_z_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
